// File: rtl/param_publish_if.sv
// param_publish_if
//   Update channel from the front-panel control/ADC scanner into the parameter publisher.
//   One beat = one (slot index, value) pair, transferred when in_valid & in_ready.
//   Signals:
//     in_valid  scanner -> publisher   beat valid
//     in_ready  publisher -> scanner   beat accepted on this edge when high
//     in_idx    scanner -> publisher   target slot
//     in_value  scanner -> publisher   new value for the slot
interface param_publish_if #(
   parameter int WIDTH = 10,
   parameter int IDX_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_idx;
   logic [WIDTH-1:0] in_value;

   modport master (output in_valid, output in_idx, output in_value, input in_ready);
   modport slave  (input in_valid, input in_idx, input in_value, output in_ready);
endinterface

// File: rtl/param_publish_tx.sv
// param_publish_tx
//   Source-side publisher for the front-panel parameter bank. Updates land in a
//   shadow bank; the whole bank is copied to params_out_o in a single edge and then
//   held stable for at least HOLD_CYCLES cycles so a far-side multi-bit sampler never
//   observes the bus in motion. Updates closer than DEADBAND to the current shadow
//   value are consumed without effect, suppressing ADC jitter.
//   Ports:
//     clk           system clock
//     rst_n         asynchronous active-low reset
//     up            update channel (slave side)
//     params_out_o  published bank, slot k = [k*WIDTH +: WIDTH]
//     published_o   1-cycle pulse: params_out_o changed on the preceding edge
//     dirty_o       shadow holds changes not yet published
//     err_idx_o     sticky flag: a beat arrived with an out-of-range index
module param_publish_tx #(
   parameter int N_PARAMS    = 12,
   parameter int WIDTH       = 10,
   parameter int HOLD_CYCLES = 64,
   parameter int DEADBAND    = 2,
   parameter int INIT_VALUE  = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   param_publish_if.slave            up,
   output logic [N_PARAMS*WIDTH-1:0] params_out_o,
   output logic                      published_o,
   output logic                      dirty_o,
   output logic                      err_idx_o
);
   localparam int IDX_W = 4;
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]          HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [WIDTH:0]            DEADBAND_W = (WIDTH + 1)'(DEADBAND);
   localparam logic [IDX_W:0]            N_PARAMS_W = (IDX_W + 1)'(N_PARAMS);
   localparam logic [WIDTH-1:0]          SLOT_INIT  = WIDTH'(INIT_VALUE);
   localparam logic [N_PARAMS*WIDTH-1:0] BANK_INIT  = {N_PARAMS{SLOT_INIT}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PUBLISH = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          hold_cnt_q, hold_cnt_d;
   logic [N_PARAMS*WIDTH-1:0] shadow_q, shadow_d;
   logic [N_PARAMS*WIDTH-1:0] params_q, params_d;
   logic                      published_q, published_d;
   logic                      dirty_q, dirty_d;
   logic                      err_q, err_d;
   logic                      ready_q, ready_d;

   logic [WIDTH-1:0]          old_val_s;
   logic                      idx_ok_s;
   logic                      accept_s;
   logic                      change_s;
   logic                      wr_s;

   // Unsigned distance between two slot values, one bit wider so it cannot wrap.
   function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH:0] ax;
      logic [WIDTH:0] bx;
      ax = {1'b0, a};
      bx = {1'b0, b};
      abs_diff = (ax >= bx) ? (ax - bx) : (bx - ax);
   endfunction

   assign idx_ok_s = ({1'b0, up.in_idx} < N_PARAMS_W);
   assign accept_s = up.in_valid & ready_q;
   assign change_s = (abs_diff(up.in_value, old_val_s) >= DEADBAND_W);
   assign wr_s     = accept_s & idx_ok_s & change_s;

   // Current shadow value of the addressed slot, for the deadband comparison.
   always_comb begin
      old_val_s = SLOT_INIT;
      for (int k = 0; k < N_PARAMS; k++) begin
         old_val_s = (up.in_idx == IDX_W'(k)) ? shadow_q[k*WIDTH +: WIDTH] : old_val_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic. When the hold expires with changes already pending,
   // go straight to PUBLISH so back-to-back publishes are exactly HOLD_CYCLES+1 apart.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            state_d = dirty_q ? ST_PUBLISH : ST_IDLE;
         end
         ST_PUBLISH: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (hold_cnt_q == {CNT_W{1'b0}}) begin
               state_d = dirty_q ? ST_PUBLISH : ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs and datapath next-state: publish copy, hold counter, shadow writes.
   always_comb begin
      ready_d     = (state_d != ST_PUBLISH);
      published_d = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      params_d    = params_q;
      shadow_d    = shadow_q;
      dirty_d     = dirty_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            hold_cnt_d = hold_cnt_q;
         end
         ST_PUBLISH: begin
            params_d    = shadow_q;
            dirty_d     = 1'b0;
            published_d = 1'b1;
            hold_cnt_d  = HOLD_LOAD;
         end
         ST_HOLD: begin
            // Saturates at zero; never wraps.
            if (hold_cnt_q != {CNT_W{1'b0}}) begin
               hold_cnt_d = hold_cnt_q - CNT_W'(1);
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
         end
         default: begin
            hold_cnt_d = {CNT_W{1'b0}};
         end
      endcase
      // ready_q is low in PUBLISH, so no write can race the publish copy.
      if (accept_s && !idx_ok_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_d;
      end
      if (wr_s) begin
         dirty_d = 1'b1;
      end else begin
         dirty_d = dirty_d;
      end
      for (int k = 0; k < N_PARAMS; k++) begin
         shadow_d[k*WIDTH +: WIDTH] = (wr_s && (up.in_idx == IDX_W'(k))) ?
                                      up.in_value : shadow_q[k*WIDTH +: WIDTH];
      end
   end

   // Datapath and output registers; reset aborts any hold or publish in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q  <= {CNT_W{1'b0}};
         shadow_q    <= BANK_INIT;
         params_q    <= BANK_INIT;
         published_q <= 1'b0;
         dirty_q     <= 1'b0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         hold_cnt_q  <= hold_cnt_d;
         shadow_q    <= shadow_d;
         params_q    <= params_d;
         published_q <= published_d;
         dirty_q     <= dirty_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
      end
   end

   assign up.in_ready  = ready_q;
   assign params_out_o = params_q;
   assign published_o  = published_q;
   assign dirty_o      = dirty_q;
   assign err_idx_o    = err_q;

endmodule

// File: tb/tb_param_publish_tx.sv
// tb_param_publish_tx
//   Directed table, hand-written multi-cycle sequences and a randomized run checked
//   against a schedule-based reference model of the parameter publisher.
module tb_param_publish_tx;
   localparam int NP   = 12;
   localparam int W    = 10;
   localparam int HOLD = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NP*W-1:0] params_out;
   logic          published;
   logic          dirty;
   logic          err_idx;

   param_publish_if #(.WIDTH(W)) up_if ();

   param_publish_tx #(
      .N_PARAMS(NP), .WIDTH(W), .HOLD_CYCLES(HOLD), .DEADBAND(2), .INIT_VALUE(0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .up(up_if),
      .params_out_o(params_out),
      .published_o(published),
      .dirty_o(dirty),
      .err_idx_o(err_idx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pub_total = 0;

   // Count publish pulses as they end.
   always @(posedge clk) begin
      if (published) pub_total <= pub_total + 1;
   end

   typedef struct {
      logic [3:0] idx;
      logic [9:0] val;
      int         chk;
      logic [9:0] exp_val;
      logic       exp_err;
      int         exp_pubs;
   } vec_t;
   vec_t tbl[10];

   // reference model state
   int m_shadow[NP];
   int m_params[NP];
   int m_dirty, m_err, m_pub, pending, pt, lastpub, e;

   function automatic logic [W-1:0] slot(input int k);
      return params_out[k*W +: W];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_bank(input string name, input logic [NP*W-1:0] act, input logic [NP*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      up_if.in_valid = 1'b0;
      up_if.in_idx   = 4'd0;
      up_if.in_value = 10'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic send_beat(input logic [3:0] idx, input logic [9:0] val);
      int n;
      n = 0;
      while (!up_if.in_ready && n < 200) begin
         tick();
         n++;
      end
      chk("beat_ready", 32'(up_if.in_ready), 32'd1);
      up_if.in_valid = 1'b1;
      up_if.in_idx   = idx;
      up_if.in_value = val;
      tick();
      up_if.in_valid = 1'b0;
   endtask

   task automatic wait_pub();
      int n;
      n = 0;
      while (!published && n < 20) begin
         tick();
         n++;
      end
      chk("pub_seen", 32'(published), 32'd1);
   endtask

   initial begin
      logic [NP*W-1:0] eb;
      int p0, cnt, stalls, old, d, base;
      logic       r_v;
      logic [3:0] r_idx;
      logic [9:0] r_val;
      int         rate;
      logic [3:0] bp_idx[4];
      logic [9:0] bp_val[4];

      tbl[0] = '{4'd3,  10'h200, 3,  10'h200, 1'b0, 1};
      tbl[1] = '{4'd2,  10'd500, 2,  10'd500, 1'b0, 1};
      tbl[2] = '{4'd2,  10'd501, 2,  10'd500, 1'b0, 0};
      tbl[3] = '{4'd2,  10'd502, 2,  10'd502, 1'b0, 1};
      tbl[4] = '{4'd12, 10'h3FF, 0,  10'd0,   1'b1, 0};
      tbl[5] = '{4'd0,  10'h3FF, 0,  10'h3FF, 1'b1, 1};
      tbl[6] = '{4'd0,  10'h3FE, 0,  10'h3FF, 1'b1, 0};
      tbl[7] = '{4'd15, 10'd0,   0,  10'h3FF, 1'b1, 0};
      tbl[8] = '{4'd0,  10'd0,   0,  10'd0,   1'b1, 1};
      tbl[9] = '{4'd11, 10'd1,   11, 10'd0,   1'b1, 0};

      rst_n = 1'b0;
      up_if.in_valid = 1'b0;
      up_if.in_idx   = 4'd0;
      up_if.in_value = 10'd0;

      // ---------- reset state ----------
      do_reset();
      chk_bank("reset_bank", params_out, '0);
      chk("reset_ready", 32'(up_if.in_ready), 32'd1);
      chk("reset_dirty", 32'(dirty), 32'd0);
      chk("reset_err", 32'(err_idx), 32'd0);
      chk("reset_pub", 32'(published), 32'd0);

      // ---------- table-driven vectors ----------
      for (int i = 0; i < 10; i++) begin
         send_beat(tbl[i].idx, tbl[i].val);
         chk($sformatf("tbl%0d_dirty", i), 32'(dirty), 32'(tbl[i].exp_pubs != 0));
         p0 = pub_total;
         repeat (80) tick();
         chk($sformatf("tbl%0d_slot", i), 32'(slot(tbl[i].chk)), 32'(tbl[i].exp_val));
         chk($sformatf("tbl%0d_err", i), 32'(err_idx), 32'(tbl[i].exp_err));
         chk($sformatf("tbl%0d_pubs", i), 32'(pub_total - p0), 32'(tbl[i].exp_pubs));
      end

      // ---------- single write latency ----------
      do_reset();
      up_if.in_valid = 1'b1;
      up_if.in_idx   = 4'd3;
      up_if.in_value = 10'h200;
      tick();
      up_if.in_valid = 1'b0;
      chk("lat_t_dirty", 32'(dirty), 32'd1);
      chk("lat_t_slot3", 32'(slot(3)), 32'd0);
      tick();
      chk("lat_t1_ready", 32'(up_if.in_ready), 32'd0);
      chk("lat_t1_slot3", 32'(slot(3)), 32'd0);
      chk("lat_t1_pub", 32'(published), 32'd0);
      tick();
      eb = '0;
      eb[3*W +: W] = 10'h200;
      chk_bank("lat_t2_bank", params_out, eb);
      chk("lat_t2_pub", 32'(published), 32'd1);
      chk("lat_t2_dirty", 32'(dirty), 32'd0);
      chk("lat_t2_ready", 32'(up_if.in_ready), 32'd1);
      tick();
      chk("lat_t3_pub", 32'(published), 32'd0);

      // ---------- hold coalescing ----------
      do_reset();
      send_beat(4'd0, 10'd100);
      wait_pub();
      chk("coal_first", 32'(slot(0)), 32'd100);
      cnt = 0;
      up_if.in_valid = 1'b1;
      up_if.in_idx   = 4'd0;
      up_if.in_value = 10'd200;
      tick();
      cnt++;
      up_if.in_idx   = 4'd5;
      up_if.in_value = 10'd7;
      tick();
      cnt++;
      up_if.in_valid = 1'b0;
      chk("coal_hold_slot0", 32'(slot(0)), 32'd100);
      while (!published && cnt < 200) begin
         tick();
         cnt++;
      end
      chk("coal_gap", 32'(cnt), 32'(HOLD + 1));
      chk("coal_slot0", 32'(slot(0)), 32'd200);
      chk("coal_slot5", 32'(slot(5)), 32'd7);
      tick();
      p0 = pub_total;
      repeat (100) tick();
      chk("coal_no_extra", 32'(pub_total - p0), 32'd0);

      // ---------- backpressure across PUBLISH ----------
      do_reset();
      bp_idx = '{4'd1, 4'd4, 4'd6, 4'd7};
      bp_val = '{10'd10, 10'd20, 10'd30, 10'd40};
      stalls = 0;
      p0 = pub_total;
      for (int b = 0; b < 4; b++) begin
         int n;
         up_if.in_valid = 1'b1;
         up_if.in_idx   = bp_idx[b];
         up_if.in_value = bp_val[b];
         n = 0;
         while (!up_if.in_ready && n < 200) begin
            stalls++;
            tick();
            n++;
         end
         tick();
      end
      up_if.in_valid = 1'b0;
      chk("bp_stalls", 32'(stalls), 32'd1);
      repeat (150) tick();
      chk("bp_slot1", 32'(slot(1)), 32'd10);
      chk("bp_slot4", 32'(slot(4)), 32'd20);
      chk("bp_slot6", 32'(slot(6)), 32'd30);
      chk("bp_slot7", 32'(slot(7)), 32'd40);
      chk("bp_pubs", 32'(pub_total - p0), 32'd2);

      // ---------- async reset mid-hold ----------
      do_reset();
      send_beat(4'd13, 10'd1);
      send_beat(4'd2, 10'd300);
      wait_pub();
      repeat (5) tick();
      send_beat(4'd2, 10'd600);
      chk("rst_pre_dirty", 32'(dirty), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_bank("rst_async_bank", params_out, '0);
      chk("rst_async_ready", 32'(up_if.in_ready), 32'd0);
      chk("rst_async_dirty", 32'(dirty), 32'd0);
      chk("rst_async_err", 32'(err_idx), 32'd0);
      chk("rst_async_pub", 32'(published), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_rel_ready", 32'(up_if.in_ready), 32'd1);
      p0 = pub_total;
      repeat (100) tick();
      chk("rst_no_pub", 32'(pub_total - p0), 32'd0);
      chk_bank("rst_bank_after", params_out, '0);

      // ---------- randomized run against reference model ----------
      do_reset();
      for (int k = 0; k < NP; k++) begin
         m_shadow[k] = 0;
         m_params[k] = 0;
      end
      m_dirty = 0; m_err = 0; m_pub = 0; pending = 0; pt = 0; lastpub = -1000; e = 0;
      rate = 30;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NP; k++) eb[k*W +: W] = W'(m_params[k]);
         chk_bank("rnd_bank", params_out, eb);
         chk("rnd_pub", 32'(published), 32'(m_pub));
         chk("rnd_dirty", 32'(dirty), 32'(m_dirty));
         chk("rnd_err", 32'(err_idx), 32'(m_err));
         chk("rnd_ready", 32'(up_if.in_ready), 32'(!(pending != 0 && pt == e + 1)));

         if (c % 200 == 0) rate = (c % 600 == 0) ? 2 : ((c % 600 == 200) ? 30 : 90);
         r_v   = ($urandom_range(0, 99) < rate);
         r_idx = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
         base  = (r_idx < NP) ? m_shadow[r_idx] : 0;
         if ($urandom_range(0, 1) == 1) begin
            base = base + $urandom_range(0, 6) - 3;
            if (base < 0) base = 0;
            if (base > 1023) base = 1023;
            r_val = 10'(base);
         end else begin
            r_val = 10'($urandom_range(0, 1023));
         end
         up_if.in_valid = r_v;
         up_if.in_idx   = r_idx;
         up_if.in_value = r_val;

         // model: what happens on the coming edge e
         e++;
         m_pub = 0;
         if (pending != 0 && pt == e) begin
            for (int k = 0; k < NP; k++) m_params[k] = m_shadow[k];
            m_dirty = 0;
            pending = 0;
            lastpub = e;
            m_pub   = 1;
         end else if (r_v) begin
            if (r_idx >= NP) begin
               m_err = 1;
            end else begin
               old = m_shadow[r_idx];
               d   = (int'(r_val) > old) ? int'(r_val) - old : old - int'(r_val);
               if (d >= 2) begin
                  m_shadow[r_idx] = int'(r_val);
                  m_dirty = 1;
                  if (pending == 0) begin
                     pending = 1;
                     pt = (e < lastpub + HOLD) ? lastpub + HOLD + 1 : e + 2;
                  end
               end
            end
         end
         tick();
      end
      up_if.in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
